// File: rtl/ram32_arb_pkg.sv
// Shared definitions for the ram32 two-port arbiter: port indices and the
// one-hot encoding of the outstanding-read owner register.
package ram32_arb_pkg;

    // Bit positions of each requester inside grant/request/owner vectors
    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    // One-hot outstanding-read owner codes
    localparam logic [1:0] RD_NONE = 2'b00;
    localparam logic [1:0] RD_I    = 2'b01;
    localparam logic [1:0] RD_D    = 2'b10;

endpackage

// File: rtl/ram32_arbiter_rr_pick2.sv
// Two-input round-robin picker. Holds the priority bit; after any grant the
// priority moves to the port that lost, so a lone requester never starves the
// other. mask_i removes the instruction port from eligibility (used by lock).
module rr_pick2
    import ram32_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       mask_i,
    output logic [1:0] gnt
);

    logic       prio;
    logic [1:0] eligible;

    assign eligible = {req[PORT_D], req[PORT_I] & ~mask_i};

    // Pick a single winner; on conflict prio selects the data port when set
    always_comb begin
        gnt = eligible;
        if (eligible == 2'b11) begin
            gnt = prio ? RD_D : RD_I;
        end
    end

    // Priority flips to the non-granted port after each grant, holds when idle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prio <= 1'b0;
        end else if (gnt != 2'b00) begin
            prio <= gnt[PORT_I];
        end
    end

endmodule

// File: rtl/ram32_arbiter.sv
// Shares one single-port ram32 between a read-only instruction port and a
// read/write data port. Round-robin on conflict, optional data-port lock for
// read-modify-write, and one-cycle read data routed to the issuing port.
module ram32_arbiter
    import ram32_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [31:0]           i_rdata,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [3:0]            d_we,
    input  logic [31:0]           d_wdata,
    input  logic                  d_lock,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [31:0]           d_rdata,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [31:0]           ram_data,
    output logic [3:0]            ram_wren,
    input  logic [31:0]           ram_q
);

    logic       locked;
    logic [1:0] rd_owner;
    logic [1:0] gnt;

    rr_pick2 u_pick (
        .clock   (clock),
        .reset_n (reset_n),
        .req     ({d_req, i_req}),
        .mask_i  (locked),
        .gnt     (gnt)
    );

    assign i_gnt = gnt[PORT_I];
    assign d_gnt = gnt[PORT_D];

    // RAM drive: granted port's address (data address when idle); writes are
    // suppressed while reset is held so nothing corrupts memory during reset
    assign ram_address = i_gnt ? i_addr : d_addr;
    assign ram_data    = d_wdata;
    assign ram_wren    = (d_gnt && reset_n) ? d_we : 4'b0000;

    // RAM output is registered, so both ports simply see q; rvalid qualifies it
    assign i_rdata  = ram_q;
    assign d_rdata  = ram_q;
    assign i_rvalid = rd_owner[PORT_I];
    assign d_rvalid = rd_owner[PORT_D];

    // Lock follows each data grant; remember which port owns next cycle's q
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked   <= 1'b0;
            rd_owner <= RD_NONE;
        end else begin
            locked   <= d_gnt & d_lock;
            rd_owner <= {d_gnt & (d_we == 4'b0000), i_gnt};
        end
    end

endmodule

// File: tb/tb_ram32_arbiter.sv
// Testbench for ram32_arbiter. A behavioural ram32 is attached to the RAM
// side. A reference model tracks whose turn it is, the exclusive lock, the
// pending reads and a shadow copy of memory, and is compared every cycle.
// Directed steps add literal expectations that pin the model itself.
module tb_ram32_arbiter;

    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          i_req, d_req, d_lock;
    logic [AW-1:0] i_addr, d_addr;
    logic [3:0]    d_we;
    logic [31:0]   d_wdata;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0]   i_rdata, d_rdata, ram_data, ram_q;
    logic [AW-1:0] ram_address;
    logic [3:0]    ram_wren;

    int checks = 0;
    int errors = 0;

    // Attached RAM and the bench's shadow copy start from the same image
    logic [31:0] mem     [0:16383] = '{4: 32'hCAFE0010, 8: 32'hBEEF0020, 12: 32'h11223344, default: 32'h0};
    logic [31:0] ref_mem [0:16383] = '{4: 32'hCAFE0010, 8: 32'hBEEF0020, 12: 32'h11223344, default: 32'h0};

    // Reference model state
    int          m_next_d;
    bit          m_excl;
    bit          m_i_pend, m_d_pend;
    logic [31:0] m_i_data, m_d_data;

    ram32_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_gnt       (i_gnt),
        .i_rvalid    (i_rvalid),
        .i_rdata     (i_rdata),
        .d_req       (d_req),
        .d_addr      (d_addr),
        .d_we        (d_we),
        .d_wdata     (d_wdata),
        .d_lock      (d_lock),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .ram_q       (ram_q)
    );

    always #5 clock = ~clock;

    // Behavioural ram32: byte-enabled write, registered read of the old word
    always @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_wren[b]) mem[ram_address[AW-1:2]][8*b +: 8] <= ram_data[8*b +: 8];
        end
        ram_q <= mem[ram_address[AW-1:2]];
    end

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model as if
    // the coming clock edge has happened
    task automatic checkOutput();
        bit          gi, gd;
        logic [31:0] word;
        if (!reset_n) begin
            checkValue("rst_wren", 32'(ram_wren), 32'h0);
            checkValue("rst_i_rvalid", 32'(i_rvalid), 32'h0);
            checkValue("rst_d_rvalid", 32'(d_rvalid), 32'h0);
            m_next_d = 0;
            m_excl   = 1'b0;
            m_i_pend = 1'b0;
            m_d_pend = 1'b0;
            return;
        end
        if (m_excl) begin
            gi = 1'b0;
            gd = d_req;
        end else if (i_req && d_req) begin
            gi = (m_next_d == 0);
            gd = (m_next_d == 1);
        end else begin
            gi = i_req;
            gd = d_req;
        end
        checkValue("i_gnt", 32'(i_gnt), 32'(gi));
        checkValue("d_gnt", 32'(d_gnt), 32'(gd));
        checkValue("ram_address", 32'(ram_address), gi ? 32'(i_addr) : 32'(d_addr));
        checkValue("ram_wren", 32'(ram_wren), gd ? 32'(d_we) : 32'h0);
        checkValue("ram_data", ram_data, d_wdata);
        checkValue("i_rvalid", 32'(i_rvalid), 32'(m_i_pend));
        checkValue("d_rvalid", 32'(d_rvalid), 32'(m_d_pend));
        if (m_i_pend) checkValue("i_rdata", i_rdata, m_i_data);
        if (m_d_pend) checkValue("d_rdata", d_rdata, m_d_data);

        if (gi) m_next_d = 1;
        if (gd) m_next_d = 0;
        m_excl   = gd && d_lock;
        m_i_pend = gi;
        m_d_pend = gd && (d_we == 4'h0);
        if (gi) m_i_data = ref_mem[i_addr[AW-1:2]];
        if (gd) begin
            word = ref_mem[d_addr[AW-1:2]];
            if (d_we == 4'h0) m_d_data = word;
            for (int b = 0; b < 4; b++) begin
                if (d_we[b]) word[8*b +: 8] = d_wdata[8*b +: 8];
            end
            ref_mem[d_addr[AW-1:2]] = word;
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, compare mid-cycle
    task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia,
                                 input logic dr, input logic [AW-1:0] da,
                                 input logic [3:0] we, input logic [31:0] wd,
                                 input logic dl);
        @(posedge clock);
        #1;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_addr  = da;
        d_we    = we;
        d_wdata = wd;
        d_lock  = dl;
        #5;
        checkOutput();
    endtask

    initial begin
        reset_n = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_lock = 1'b0;
        i_addr = '0; d_addr = '0; d_we = 4'h0; d_wdata = 32'h0;
        m_next_d = 0; m_excl = 1'b0; m_i_pend = 1'b0; m_d_pend = 1'b0;
        m_i_data = 32'h0; m_d_data = 32'h0;

        // Reset held with requests active, including a lone data write
        applyStimulus(1, 16'h0010, 1, 16'h0020, 4'hF, 32'hDEADBEEF, 0);
        applyStimulus(0, 16'h0010, 1, 16'h0020, 4'hF, 32'hDEADBEEF, 0);
        d_req = 1'b0; d_we = 4'h0;
        reset_n = 1'b1;

        // Alternation: both reading continuously
        applyStimulus(1, 16'h0010, 1, 16'h0020, 4'h0, 32'h0, 0);
        checkValue("first_gnt_is_i", 32'(i_gnt), 32'h1);
        applyStimulus(1, 16'h0010, 1, 16'h0020, 4'h0, 32'h0, 0);
        checkValue("alt_d_gnt", 32'(d_gnt), 32'h1);
        checkValue("alt_i_data", i_rdata, 32'hCAFE0010);
        applyStimulus(1, 16'h0010, 1, 16'h0020, 4'h0, 32'h0, 0);
        checkValue("alt_i_gnt", 32'(i_gnt), 32'h1);
        checkValue("alt_d_rvalid", 32'(d_rvalid), 32'h1);
        checkValue("alt_d_data", d_rdata, 32'hBEEF0020);
        applyStimulus(0, 16'h0010, 0, 16'h0020, 4'h0, 32'h0, 0);
        checkValue("alt_i_rvalid", 32'(i_rvalid), 32'h1);

        // Byte write then immediate read-back of the same word
        applyStimulus(0, 16'h0010, 1, 16'h0030, 4'b0010, 32'h0000AB00, 0);
        applyStimulus(0, 16'h0010, 1, 16'h0030, 4'b0000, 32'h0, 0);
        checkValue("wr_no_rvalid", 32'(d_rvalid), 32'h0);
        applyStimulus(0, 16'h0010, 0, 16'h0030, 4'b0000, 32'h0, 0);
        checkValue("bw_rvalid", 32'(d_rvalid), 32'h1);
        checkValue("bw_data", d_rdata, 32'h1122AB44);

        // Lock: I wins first, then locked D read, then D write releasing lock
        applyStimulus(1, 16'h0010, 1, 16'h0030, 4'h0, 32'h0, 1);
        applyStimulus(1, 16'h0010, 1, 16'h0030, 4'h0, 32'h0, 1);
        checkValue("lock_rd_i_gnt", 32'(i_gnt), 32'h0);
        applyStimulus(1, 16'h0010, 1, 16'h0030, 4'b0001, 32'h000000EE, 0);
        checkValue("lock_wr_i_gnt", 32'(i_gnt), 32'h0);
        checkValue("lock_rd_data", d_rdata, 32'h1122AB44);
        applyStimulus(1, 16'h0010, 0, 16'h0030, 4'h0, 32'h0, 0);
        checkValue("unlock_i_gnt", 32'(i_gnt), 32'h1);
        applyStimulus(0, 16'h0010, 0, 16'h0030, 4'h0, 32'h0, 0);

        // Reset pulsed while an instruction read is outstanding
        applyStimulus(1, 16'h0020, 0, 16'h0030, 4'h0, 32'h0, 0);
        reset_n = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
        #1;
        checkOutput();
        #1;
        reset_n = 1'b1;
        applyStimulus(0, 16'h0020, 0, 16'h0030, 4'h0, 32'h0, 0);
        checkValue("rst_drop_rvalid", 32'(i_rvalid), 32'h0);
        applyStimulus(1, 16'h0010, 1, 16'h0030, 4'h0, 32'h0, 0);
        checkValue("rst_prio_i", 32'(i_gnt), 32'h1);

        // Idle for five cycles; priority must still favour D afterwards
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 16'h0010, 0, 16'h0030, 4'h0, 32'h0, 0);
            checkValue("idle_wren", 32'(ram_wren), 32'h0);
        end
        applyStimulus(1, 16'h0010, 1, 16'h0030, 4'h0, 32'h0, 0);
        checkValue("idle_prio_d", 32'(d_gnt), 32'h1);
        applyStimulus(0, 16'h0010, 0, 16'h0030, 4'h0, 32'h0, 0);
        checkValue("final_data", d_rdata, 32'h1122ABEE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
